// File: rtl/gpu_instruction_issuer_if.sv
// Host, scan-position and control-unit signals of the instruction issuer.
// The master side is the host/scan generator; the slave side is the issuer.
interface gpu_instruction_issuer_if #(
  parameter int DEPTH = 8
);
  logic [9:0]               SYS_X;
  logic [9:0]               SYS_Y;
  logic [31:0]              HOST_DATA;
  logic                     HOST_VALID;
  logic                     HOST_READY;
  logic [31:0]              INS;
  logic                     INS_VALID;
  logic                     BUSY;
  logic [$clog2(DEPTH):0]   FIFO_LEVEL;

  modport master (
    output SYS_X, SYS_Y, HOST_DATA, HOST_VALID,
    input  HOST_READY, INS, INS_VALID, BUSY, FIFO_LEVEL
  );

  modport slave (
    input  SYS_X, SYS_Y, HOST_DATA, HOST_VALID,
    output HOST_READY, INS, INS_VALID, BUSY, FIFO_LEVEL
  );
endinterface

// File: rtl/gpu_instruction_issuer.sv
// Buffers host instruction words and bursts them onto INS in the vertical-blanking window.
// Optional end-of-list marker word after a completed burst: define INS_END_MARKER_EN.
module gpu_instruction_issuer #(
  parameter int          DEPTH     = 8,
  parameter int          BURST_LEN = 5,
  parameter int          V_ACTIVE  = 480,
  parameter logic [31:0] IDLE_WORD = 32'hFFFF_FFFF
) (
  input logic CLK,
  input logic RST,
  gpu_instruction_issuer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BURST  = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
`ifdef INS_END_MARKER_EN
  localparam logic [1:0] ST_MARKER = 2'd3;
`endif

  logic [1:0]    state;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [AW:0]   level_next;
  logic          full_q;
  logic [CW-1:0] burst_cnt;
  logic [31:0]   ins_q;
  logic          ins_valid_q;

  logic push;
  logic pop;
  logic abort;
  logic trigger;
  logic last_word;
  logic going_empty;

  // Pops only read the registered level, so a word pushed into an empty FIFO waits a cycle.
  always_comb begin
    push        = bus.HOST_VALID && !full_q;
    abort       = (bus.SYS_Y < V_ACTIVE_L);
    trigger     = (bus.SYS_Y == V_ACTIVE_L) && (bus.SYS_X == 10'd0);
    pop         = (state == ST_BURST) && !abort && (level != '0);
    last_word   = (burst_cnt == CW'(BURST_LEN - 1));
    going_empty = (level == (AW+1)'(1)) && !push;
    level_next  = level;
    if (push && !pop) begin
      level_next = level + (AW+1)'(1);
    end else if (!push && pop) begin
      level_next = level - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.HOST_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level  <= level_next;
      full_q <= (level_next == (AW+1)'(DEPTH));
    end
  end

  // Frame sequencing: one burst per frame, rearmed when the scan returns to line 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_IDLE;
      ins_q       <= IDLE_WORD;
      ins_valid_q <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ins_q       <= IDLE_WORD;
          ins_valid_q <= 1'b0;
          burst_cnt   <= '0;
          if (trigger) begin
            state <= (level != '0) ? ST_BURST : ST_DONE;
          end
        end
        ST_BURST: begin
          if (abort) begin
            ins_q       <= IDLE_WORD;
            ins_valid_q <= 1'b0;
            burst_cnt   <= '0;
            state       <= ST_DONE;
          end else if (level != '0) begin
            ins_q       <= mem[rd_ptr];
            ins_valid_q <= 1'b1;
            burst_cnt   <= burst_cnt + CW'(1);
            if (last_word || going_empty) begin
`ifdef INS_END_MARKER_EN
              state <= ST_MARKER;
`else
              state <= ST_DONE;
`endif
            end
          end else begin
            ins_q       <= IDLE_WORD;
            ins_valid_q <= 1'b0;
            state       <= ST_DONE;
          end
        end
`ifdef INS_END_MARKER_EN
        ST_MARKER: begin
          ins_q       <= 32'h0000_0000;
          ins_valid_q <= 1'b1;
          burst_cnt   <= '0;
          state       <= ST_DONE;
        end
`endif
        ST_DONE: begin
          ins_q       <= IDLE_WORD;
          ins_valid_q <= 1'b0;
          burst_cnt   <= '0;
          if (bus.SYS_Y == 10'd0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          ins_q       <= IDLE_WORD;
          ins_valid_q <= 1'b0;
          burst_cnt   <= '0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.HOST_READY = !full_q;
  assign bus.INS        = ins_q;
  assign bus.INS_VALID  = ins_valid_q;
  assign bus.FIFO_LEVEL = level;
`ifdef INS_END_MARKER_EN
  assign bus.BUSY       = (state == ST_BURST) || (state == ST_MARKER);
`else
  assign bus.BUSY       = (state == ST_BURST);
`endif

endmodule

// File: tb/tb_gpu_instruction_issuer.sv
// Randomized and directed bench for gpu_instruction_issuer against a queue-based frame model.
// The model appends the end-of-list marker when INS_END_MARKER_EN is defined.
module tb_gpu_instruction_issuer;

  localparam int DEPTH     = 8;
  localparam int BURST_LEN = 5;
  localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;
`ifdef INS_END_MARKER_EN
  localparam bit MARKER_EN = 1'b1;
`else
  localparam bit MARKER_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;

  gpu_instruction_issuer_if #(.DEPTH(DEPTH)) bus ();

  gpu_instruction_issuer #(
    .DEPTH(DEPTH), .BURST_LEN(BURST_LEN), .V_ACTIVE(480), .IDLE_WORD(IDLE_WORD)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int first_idx;
  int last_idx;
  int idle_bad;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Push one word through the handshake; the model accepts it only if it has room.
  task automatic push_word(input logic [31:0] d);
    bus.HOST_DATA  = d;
    bus.HOST_VALID = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(d);
    tick();
    bus.HOST_VALID = 1'b0;
  endtask

  task automatic trigger();
    bus.SYS_Y = 10'd480;
    bus.SYS_X = 10'd0;
    tick();
    bus.SYS_X = 10'd1;
  endtask

  task automatic rearm();
    bus.SYS_Y = 10'd0;
    bus.SYS_X = 10'd0;
    tick();
    bus.SYS_Y = 10'd100;
    bus.SYS_X = 10'd5;
    tick();
  endtask

  task automatic start_capture();
    got_q.delete();
    first_idx = -1;
    last_idx  = -1;
    idle_bad  = 0;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.INS_VALID === 1'b1) begin
        got_q.push_back(bus.INS);
        if (first_idx < 0) first_idx = i;
        last_idx = i;
      end else if (bus.INS !== IDLE_WORD) begin
        idle_bad++;
      end
    end
  endtask

  // A frame issues the oldest min(BURST_LEN, stored) words, plus a marker if any were issued.
  task automatic build_expected();
    int n;
    exp_q.delete();
    n = (model_q.size() < BURST_LEN) ? model_q.size() : BURST_LEN;
    for (int i = 0; i < n; i++) exp_q.push_back(model_q.pop_front());
    if (n > 0 && MARKER_EN) exp_q.push_back(32'h0000_0000);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.HOST_VALID = 1'b1;
    bus.HOST_DATA  = 32'h0000_0123;
    bus.SYS_X = 10'd0;
    bus.SYS_Y = 10'd100;
    tick();
    tick();
    checks++;
    if (bus.INS !== IDLE_WORD) begin
      errors++; $display("[TB] FAIL reset_ins got %h want %h", bus.INS, IDLE_WORD);
    end
    checks++;
    if (bus.INS_VALID !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ins_valid got %b want 0", bus.INS_VALID);
    end
    checks++;
    if (bus.FIFO_LEVEL !== 0) begin
      errors++; $display("[TB] FAIL reset_level got %0d want 0", bus.FIFO_LEVEL);
    end
    checks++;
    if (bus.HOST_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_busy got %b%b want 10", bus.HOST_READY, bus.BUSY);
    end
    RST = 1'b0;
    bus.HOST_VALID = 1'b0;
    tick();
    checks++;
    if (bus.FIFO_LEVEL !== 0) begin
      errors++; $display("[TB] FAIL reset_no_push got %0d want 0", bus.FIFO_LEVEL);
    end
  endtask

  task automatic test_basic_burst();
    for (int i = 1; i <= 5; i++) push_word(32'(i * 10));
    checks++;
    if (bus.FIFO_LEVEL !== 5) begin
      errors++; $display("[TB] FAIL basic_level_pre got %0d want 5", bus.FIFO_LEVEL);
    end
    trigger();
    checks++;
    if (bus.BUSY !== 1'b1 || bus.INS_VALID !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_trigger got busy %b valid %b want 1 0", bus.BUSY, bus.INS_VALID);
    end
    build_expected();
    start_capture();
    collect(10);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL basic_count got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("[TB] FAIL basic_word%0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (first_idx != 0 || (last_idx - first_idx + 1) != got_q.size()) begin
      errors++; $display("[TB] FAIL basic_timing got first %0d last %0d want first 0 contiguous", first_idx, last_idx);
    end
    checks++;
    if (idle_bad != 0 || bus.INS !== IDLE_WORD) begin
      errors++; $display("[TB] FAIL basic_idle got %0d bad idle cycles, ins %h want 0, %h", idle_bad, bus.INS, IDLE_WORD);
    end
    checks++;
    if (bus.FIFO_LEVEL !== 0 || bus.BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL basic_after got level %0d busy %b want 0 0", bus.FIFO_LEVEL, bus.BUSY);
    end
    rearm();
  endtask

  task automatic test_burst_limit();
    for (int i = 1; i <= 8; i++) push_word(32'(i));
    checks++;
    if (bus.HOST_READY !== 1'b0 || bus.FIFO_LEVEL !== 8) begin
      errors++; $display("[TB] FAIL limit_full got ready %b level %0d want 0 8", bus.HOST_READY, bus.FIFO_LEVEL);
    end
    push_word(32'd99);
    checks++;
    if (bus.FIFO_LEVEL !== 8) begin
      errors++; $display("[TB] FAIL limit_refuse got %0d want 8", bus.FIFO_LEVEL);
    end
    trigger();
    build_expected();
    start_capture();
    collect(10);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL limit_burst1 got %0d words first %h want %0d words first %h",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'hx, exp_q.size(), exp_q[0]);
    end
    checks++;
    if (bus.FIFO_LEVEL !== 3) begin
      errors++; $display("[TB] FAIL limit_level got %0d want 3", bus.FIFO_LEVEL);
    end
    start_capture();
    bus.SYS_X = 10'd0;
    collect(4);
    checks++;
    if (got_q.size() != 0) begin
      errors++; $display("[TB] FAIL limit_once_per_frame got %0d words want 0", got_q.size());
    end
    rearm();
    trigger();
    build_expected();
    start_capture();
    collect(8);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL limit_burst2 got %0d words want %0d (6,7,8)", got_q.size(), exp_q.size());
    end
    checks++;
    if (bus.FIFO_LEVEL !== 0) begin
      errors++; $display("[TB] FAIL limit_drained got %0d want 0", bus.FIFO_LEVEL);
    end
    rearm();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) push_word(32'hA0 + 32'(i));
    trigger();
    build_expected();
    start_capture();
    bus.HOST_VALID = 1'b1;
    bus.HOST_DATA  = 32'h0000_DEAD;
    collect(1);
    checks++;
    if (bus.FIFO_LEVEL !== 7 || bus.HOST_READY !== 1'b1) begin
      errors++; $display("[TB] FAIL fullpp_refuse got level %0d ready %b want 7 1", bus.FIFO_LEVEL, bus.HOST_READY);
    end
    bus.HOST_DATA = 32'h0000_BEEF;
    collect(1);
    model_q.push_back(32'h0000_BEEF);
    checks++;
    if (bus.FIFO_LEVEL !== 7) begin
      errors++; $display("[TB] FAIL fullpp_accept got level %0d want 7", bus.FIFO_LEVEL);
    end
    bus.HOST_VALID = 1'b0;
    collect(8);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL fullpp_burst got %0d words want %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (bus.FIFO_LEVEL !== model_q.size()) begin
      errors++; $display("[TB] FAIL fullpp_level got %0d want %0d", bus.FIFO_LEVEL, model_q.size());
    end
    rearm();
    trigger();
    build_expected();
    start_capture();
    collect(10);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL fullpp_drain got %0d words last %h want %0d words incl BEEF",
                         got_q.size(), (got_q.size() > 0) ? got_q[got_q.size()-1] : 32'hx, exp_q.size());
    end
    rearm();
  endtask

  task automatic test_frame_abort();
    for (int i = 0; i < 5; i++) push_word(32'hC0 + 32'(i));
    trigger();
    exp_q.delete();
    exp_q.push_back(model_q.pop_front());
    exp_q.push_back(model_q.pop_front());
    start_capture();
    collect(2);
    bus.SYS_Y = 10'd0;
    collect(1);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL abort_words got %0d words want 2", got_q.size());
    end
    checks++;
    if (bus.INS_VALID !== 1'b0 || bus.INS !== IDLE_WORD || bus.BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_drop got valid %b ins %h busy %b want 0 %h 0", bus.INS_VALID, bus.INS, bus.BUSY, IDLE_WORD);
    end
    checks++;
    if (bus.FIFO_LEVEL !== 3) begin
      errors++; $display("[TB] FAIL abort_level got %0d want 3", bus.FIFO_LEVEL);
    end
    rearm();
    trigger();
    build_expected();
    start_capture();
    collect(8);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL abort_resume got %0d words want %0d", got_q.size(), exp_q.size());
    end
    rearm();
  endtask

  task automatic test_empty_frame();
    trigger();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_busy got %b want 0", bus.BUSY);
    end
    push_word(32'd77);
    start_capture();
    collect(5);
    checks++;
    if (got_q.size() != 0 || bus.FIFO_LEVEL !== 1) begin
      errors++; $display("[TB] FAIL empty_frame got %0d words level %0d want 0 1", got_q.size(), bus.FIFO_LEVEL);
    end
    rearm();
    trigger();
    build_expected();
    start_capture();
    collect(6);
    checks++;
    if (got_q != exp_q) begin
      errors++; $display("[TB] FAIL empty_next got %0d words want %0d", got_q.size(), exp_q.size());
    end
    rearm();
  endtask

  task automatic test_random();
    int ncyc;
    for (int it = 0; it < 8; it++) begin
      ncyc = $urandom_range(2, 14);
      for (int c = 0; c < ncyc; c++) begin
        bus.HOST_VALID = 1'($urandom_range(0, 1));
        bus.HOST_DATA  = $urandom;
        if (bus.HOST_VALID && model_q.size() < DEPTH) model_q.push_back(bus.HOST_DATA);
        tick();
      end
      bus.HOST_VALID = 1'b0;
      checks++;
      if (bus.FIFO_LEVEL !== model_q.size()) begin
        errors++; $display("[TB] FAIL rand%0d_level got %0d want %0d", it, bus.FIFO_LEVEL, model_q.size());
      end
      trigger();
      build_expected();
      start_capture();
      collect(12);
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("[TB] FAIL rand%0d_count got %0d want %0d", it, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin
            errors++; $display("[TB] FAIL rand%0d_word%0d got %h want %h", it, i, got_q[i], exp_q[i]);
          end
        end
      end
      checks++;
      if (idle_bad != 0 || bus.FIFO_LEVEL !== model_q.size()) begin
        errors++; $display("[TB] FAIL rand%0d_after got idle_bad %0d level %0d want 0 %0d", it, idle_bad, bus.FIFO_LEVEL, model_q.size());
      end
      rearm();
    end
  endtask

  initial begin
    bus.HOST_VALID = 1'b0;
    bus.HOST_DATA  = '0;
    bus.SYS_X = 10'd0;
    bus.SYS_Y = 10'd100;
    test_reset();
    test_basic_burst();
    test_burst_limit();
    test_full_push_pop();
    test_frame_abort();
    test_empty_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
